ysyx_22041752_mul_ctrl: RTL

//  EXE-stage sequencer directly upstream of the iterative multiplier (ysyx_22041752_mul).
//  - Accepts one RV64M multiply per valid/ready handshake from the EXE issue logic.
//  - Latches operands, op and destination tag, and decodes op into mul_u/mul_su/mul_h.
//  - Holds mul_valid with stable operands until the multiplier reports done.
//  - Formats the result (including MULW sign-extension) and returns it to writeback on a

---
 rtl/ysyx_22041752_mul_ctrl_if.sv | 27 ++
 rtl/ysyx_22041752_mul_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mul_ctrl_if.sv
// Issue and writeback handshake bundle for the EXE-stage multiply sequencer.
// The master side issues ops and accepts results; the slave side is the sequencer.
interface ysyx_22041752_mul_ctrl_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/ysyx_22041752_mul_ctrl.sv
// EXE-stage sequencer in front of the iterative multiplier: accepts one RV64M multiply,
// holds stable operands until the multiplier is done, formats and returns the result.
module ysyx_22041752_mul_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  ysyx_22041752_mul_ctrl_if.slave  bus,
  output logic                     mul_valid,
  output logic                     mul_u,
  output logic                     mul_su,
  output logic                     mul_h,
  output logic [XLEN-1:0]          mul_a,
  output logic [XLEN-1:0]          mul_b,
  input  logic [XLEN-1:0]          mul_product,
  input  logic                     mul_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             in_ready, out_valid;
  logic             dec_u, dec_su, dec_h, dec_w;
  logic             w_q;
  logic [XLEN-1:0]  src1_fmt, src2_fmt, result;
  logic [XLEN-1:0]  out_data_q;
  logic [TAG_W-1:0] tag_q, out_tag_q;

  always_comb begin
    dec_u  = 1'b0;
    dec_su = 1'b0;
    dec_h  = 1'b0;
    dec_w  = 1'b0;
    case (bus.in_op)
      3'b001:  dec_h = 1'b1;
      3'b010:  begin dec_su = 1'b1; dec_h = 1'b1; end
      3'b011:  begin dec_u  = 1'b1; dec_h = 1'b1; end
      3'b100:  dec_w = 1'b1;
      default: ;
    endcase
  end

  // MULW operands are sign-extended at latch time so the multiplier sees a plain MUL.
  assign src1_fmt = dec_w ? {{(XLEN-32){bus.in_src1[31]}}, bus.in_src1[31:0]} : bus.in_src1;
  assign src2_fmt = dec_w ? {{(XLEN-32){bus.in_src2[31]}}, bus.in_src2[31:0]} : bus.in_src2;
  assign result   = w_q ? {{(XLEN-32){mul_product[31]}}, mul_product[31:0]} : mul_product;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_valid = 1'b0;
    accept    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: in_ready = ~flush;
        BUSY: begin
          mul_valid = ~flush;
          if (mul_done) state_d = DONE;
        end
        DONE: begin
          out_valid = ~flush;
          in_ready  = bus.out_ready & ~flush;
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      accept = in_ready & bus.in_valid;
      if (accept) state_d = BUSY;
      // flush outranks every other transition
      if (flush) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_u      <= 1'b0;
      mul_su     <= 1'b0;
      mul_h      <= 1'b0;
      w_q        <= 1'b0;
      tag_q      <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mul_a  <= src1_fmt;
        mul_b  <= src2_fmt;
        mul_u  <= dec_u;
        mul_su <= dec_su;
        mul_h  <= dec_h;
        w_q    <= dec_w;
        tag_q  <= bus.in_tag;
      end
      if (state_q == BUSY && mul_done && !flush) begin
        out_data_q <= result;
        out_tag_q  <= tag_q;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

endmodule
